// File: rtl/regfile_writeback_queue_pkg.sv
// rtl/regfile_writeback_queue_pkg.sv - shared widths, default depth and entry type for the writeback queue
// Register file is 8 entries wide; these defaults size the queue and its forwarding search.
package regfile_writeback_queue_pkg;

  localparam int REGISTER_ADDRESS_BITS = 3;
  localparam int REGISTER_DATA_BITS    = 8;
  localparam int WB_QUEUE_DEPTH        = 4;

  typedef struct packed {
    logic [REGISTER_ADDRESS_BITS-1:0] addr;
    logic [REGISTER_DATA_BITS-1:0]    data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_queue_forward_match.sv
// rtl/regfile_writeback_queue_forward_match.sv - age-ordered search of pending writes for a register index
// Used only when WB_FORWARD_EN is defined; the youngest matching entry supplies the data.
module wb_forward_match
  import regfile_writeback_queue_pkg::*;
#(
  parameter int ADDR_BITS = REGISTER_ADDRESS_BITS,
  parameter int DATA_BITS = REGISTER_DATA_BITS,
  parameter int DEPTH     = WB_QUEUE_DEPTH,
  parameter int PTR_BITS  = $clog2(DEPTH)
) (
  input  logic [ADDR_BITS-1:0] addr_q [DEPTH],
  input  logic [DATA_BITS-1:0] data_q [DEPTH],
  input  logic [PTR_BITS-1:0]  rd_ptr,
  input  logic [PTR_BITS:0]    count,
  input  logic [ADDR_BITS-1:0] fwd_addr,
  output logic                 fwd_hit,
  output logic [DATA_BITS-1:0] fwd_data
);

  logic [PTR_BITS-1:0] idx;

  // Walk oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = rd_ptr;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_BITS'(k);
      if (((PTR_BITS+1)'(k) < count) && (addr_q[idx] == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

endmodule

// File: rtl/regfile_writeback_queue.sv
// rtl/regfile_writeback_queue.sv - in-order writeback queue feeding the register file write port
// Optional bypass lookup of pending writes is enabled by defining WB_FORWARD_EN.
module regfile_writeback_queue
  import regfile_writeback_queue_pkg::*;
#(
  parameter int ADDR_BITS = REGISTER_ADDRESS_BITS,
  parameter int DATA_BITS = REGISTER_DATA_BITS,
  parameter int DEPTH     = WB_QUEUE_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_BITS-1:0]     req_addr,
  input  logic [DATA_BITS-1:0]     req_data,
  input  logic                     wr_stall,
  output logic [ADDR_BITS-1:0]     wr_addr,
  output logic                     wr_enable,
  output logic [DATA_BITS-1:0]     wr_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
`ifdef WB_FORWARD_EN
  ,
  input  logic [ADDR_BITS-1:0]     fwd_addr,
  output logic                     fwd_hit,
  output logic [DATA_BITS-1:0]     fwd_data
`endif
);

  localparam int PTR_BITS = $clog2(DEPTH);

  logic [PTR_BITS-1:0]  rd_ptr;
  logic [PTR_BITS-1:0]  wr_ptr;
  logic [PTR_BITS:0]    count_q;
  logic [ADDR_BITS-1:0] addr_q [DEPTH];
  logic [DATA_BITS-1:0] data_q [DEPTH];
  logic                 push;
  logic                 pop;

  assign empty     = (count_q == '0);
  assign req_ready = (count_q != (PTR_BITS+1)'(DEPTH));
  assign wr_enable = !empty && !wr_stall;
  assign push      = req_valid && req_ready;
  assign pop       = wr_enable;
  assign count     = count_q;
  assign wr_addr   = empty ? '0 : addr_q[rd_ptr];
  assign wr_data   = empty ? '0 : data_q[rd_ptr];

  // Power-of-two depth lets the pointers wrap naturally; count alone decides full/empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage needs no reset: the count gates every read of it.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= req_addr;
      data_q[wr_ptr] <= req_data;
    end
  end

`ifdef WB_FORWARD_EN
  wb_forward_match #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (DATA_BITS),
    .DEPTH     (DEPTH),
    .PTR_BITS  (PTR_BITS)
  ) u_forward_match (
    .addr_q   (addr_q),
    .data_q   (data_q),
    .rd_ptr   (rd_ptr),
    .count    (count_q),
    .fwd_addr (fwd_addr),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data)
  );
`endif

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// tb/tb_regfile_writeback_queue.sv - directed vector bench for regfile_writeback_queue (WB_FORWARD_EN optional)
module tb_regfile_writeback_queue;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_addr;
  logic [7:0] req_data;
  logic       wr_stall;
  logic [2:0] wr_addr;
  logic       wr_enable;
  logic [7:0] wr_data;
  logic [2:0] count;
  logic       empty;
  logic [2:0] fwd_addr;
  logic       fwd_hit;
  logic [7:0] fwd_data;

  regfile_writeback_queue dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .wr_stall  (wr_stall),
    .wr_addr   (wr_addr),
    .wr_enable (wr_enable),
    .wr_data   (wr_data),
    .count     (count),
    .empty     (empty)
`ifdef WB_FORWARD_EN
    ,
    .fwd_addr  (fwd_addr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [2:0] a;
    logic [7:0] d;
    logic       s;
    logic [2:0] e_count;
    logic       e_ready;
    logic       e_empty;
    logic       e_wen;
    logic [2:0] e_addr;
    logic [7:0] e_data;
  } vec_t;

  typedef struct {
    logic [2:0] a;
    logic [7:0] d;
  } ent_t;

  vec_t       tv[$];
  ent_t       sb[$];
  logic [7:0] rf     [8];
  logic [7:0] exp_rf [8];
  int         total = 0;
  int         bad = 0;
  int         n_writes = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic void add(input logic v, input logic [2:0] a, input logic [7:0] d, input logic s,
                              input logic [2:0] ec, input logic er, input logic ee, input logic ew,
                              input logic [2:0] ea, input logic [7:0] ed);
    vec_t t;
    t.v = v; t.a = a; t.d = d; t.s = s;
    t.e_count = ec; t.e_ready = er; t.e_empty = ee; t.e_wen = ew; t.e_addr = ea; t.e_data = ed;
    tv.push_back(t);
  endfunction

  // Drive one cycle's inputs after the falling edge and log what the next rising edge will commit.
  task automatic drive(input logic v, input logic [2:0] a, input logic [7:0] d, input logic s);
    ent_t e;
    @(negedge clk);
    req_valid = v;
    req_addr  = a;
    req_data  = d;
    wr_stall  = s;
    #1;
    if (wr_enable) begin
      n_writes++;
      rf[wr_addr] = wr_data;
      if (sb.size() == 0) begin
        chk("sb_unexpected_write", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("sb_wr_addr", {29'd0, wr_addr}, {29'd0, e.a});
        chk("sb_wr_data", {24'd0, wr_data}, {24'd0, e.d});
      end
    end
    if (v && req_ready) begin
      e.a = a;
      e.d = d;
      sb.push_back(e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    wr_stall  = 1'b0;
    fwd_addr  = '0;
    for (int i = 0; i < 8; i++) rf[i] = 8'h00;

    // Vector table: inputs for the cycle, then outputs expected before that cycle's edge.
    for (int i = 0; i < 10; i++) add(0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 8'h00);
    add(1, 3, 8'h5A, 0, 0, 1, 1, 0, 0, 8'h00);
    add(0, 0, 8'h00, 0, 1, 1, 0, 1, 3, 8'h5A);
    add(0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 8'h00);
    add(1, 1, 8'h11, 1, 0, 1, 1, 0, 0, 8'h00);
    add(1, 2, 8'h22, 1, 1, 1, 0, 0, 1, 8'h11);
    add(1, 3, 8'h33, 1, 2, 1, 0, 0, 1, 8'h11);
    add(1, 4, 8'h44, 1, 3, 1, 0, 0, 1, 8'h11);
    add(1, 5, 8'h55, 1, 4, 0, 0, 0, 1, 8'h11);
    add(1, 5, 8'h55, 1, 4, 0, 0, 0, 1, 8'h11);
    add(0, 0, 8'h00, 0, 4, 0, 0, 1, 1, 8'h11);
    add(0, 0, 8'h00, 0, 3, 1, 0, 1, 2, 8'h22);
    add(0, 0, 8'h00, 0, 2, 1, 0, 1, 3, 8'h33);
    add(0, 0, 8'h00, 0, 1, 1, 0, 1, 4, 8'h44);
    add(0, 0, 8'h00, 0, 0, 1, 1, 0, 0, 8'h00);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_wen", {31'd0, wr_enable}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    foreach (tv[i]) begin
      drive(tv[i].v, tv[i].a, tv[i].d, tv[i].s);
      chk($sformatf("vec%0d_count", i), {29'd0, count}, {29'd0, tv[i].e_count});
      chk($sformatf("vec%0d_ready", i), {31'd0, req_ready}, {31'd0, tv[i].e_ready});
      chk($sformatf("vec%0d_empty", i), {31'd0, empty}, {31'd0, tv[i].e_empty});
      chk($sformatf("vec%0d_wen", i), {31'd0, wr_enable}, {31'd0, tv[i].e_wen});
      chk($sformatf("vec%0d_addr", i), {29'd0, wr_addr}, {29'd0, tv[i].e_addr});
      chk($sformatf("vec%0d_data", i), {24'd0, wr_data}, {24'd0, tv[i].e_data});
    end
    chk("vec_writes", n_writes, 32'd5);

    // Steady push+pop at count 2 across several pointer wraps.
    for (int i = 0; i < 8; i++) begin
      rf[i]     = 8'hEE;
      exp_rf[i] = 8'hEE;
    end
    for (int i = 0; i < 22; i++) begin
      logic [2:0] a;
      logic [7:0] d;
      a = 3'((i * 3) % 8);
      d = 8'(8'h80 + i);
      exp_rf[a] = d;
      drive(1'b1, a, d, (i < 2) ? 1'b1 : 1'b0);
      if (i >= 2) chk($sformatf("steady%0d_count", i), {29'd0, count}, 32'd2);
    end
    begin
      int budget;
      budget = 0;
      while (!empty && budget < 10) begin
        drive(0, 0, 8'h00, 0);
        budget++;
      end
      chk("drain_empty", {31'd0, empty}, 32'd1);
    end
    for (int i = 0; i < 8; i++) chk($sformatf("rf_r%0d", i), {24'd0, rf[i]}, {24'd0, exp_rf[i]});

    // Asynchronous reset in the middle of a drain.
    drive(1, 5, 8'hA5, 1);
    drive(1, 6, 8'hB6, 1);
    drive(1, 7, 8'hC7, 1);
    @(negedge clk);
    req_valid = 1'b0;
    wr_stall  = 1'b0;
    #1;
    chk("mid_count", {29'd0, count}, 32'd3);
    chk("mid_wen", {31'd0, wr_enable}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_wen", {31'd0, wr_enable}, 32'd0);
    chk("arst_count", {29'd0, count}, 32'd0);
    chk("arst_empty", {31'd0, empty}, 32'd1);
    chk("arst_ready", {31'd0, req_ready}, 32'd1);
    chk("arst_wr_addr", {29'd0, wr_addr}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    begin
      int nw;
      nw = n_writes;
      repeat (5) drive(0, 0, 8'h00, 0);
      chk("post_rst_writes", n_writes, nw);
      chk("post_rst_count", {29'd0, count}, 32'd0);
    end

`ifdef WB_FORWARD_EN
    drive(1, 2, 8'h10, 1);
    drive(1, 2, 8'h20, 1);
    drive(0, 0, 8'h00, 1);
    fwd_addr = 3'd2;
    #1;
    chk("fwd_hit_r2", {31'd0, fwd_hit}, 32'd1);
    chk("fwd_data_r2", {24'd0, fwd_data}, 32'h20);
    fwd_addr = 3'd5;
    #1;
    chk("fwd_hit_r5", {31'd0, fwd_hit}, 32'd0);
    drive(0, 0, 8'h00, 0);
    fwd_addr = 3'd2;
    #1;
    chk("fwd_hit_head", {31'd0, fwd_hit}, 32'd1);
    chk("fwd_data_head", {24'd0, fwd_data}, 32'h20);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
